// File: rtl/riscv_mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: opcodes, FSM states,
// ALU operations, datapath mux selects and trap causes.
package riscv_mc_pkg;

   typedef enum logic [6:0] {
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_R      = 7'b0110011,
      OP_I      = 7'b0010011,
      OP_BRANCH = 7'b1100011,
      OP_JAL    = 7'b1101111,
      OP_JALR   = 7'b1100111,
      OP_LUI    = 7'b0110111,
      OP_AUIPC  = 7'b0010111
   } opcodetype;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
      ALUWB, BRANCH, JAL, JALRADR, LUI, AUIPC, TRAP
   } statetype;

   // Operation class handed from the FSM to the ALU decoder.
   typedef enum logic [2:0] {
      ALUOP_ADD, ALUOP_R, ALUOP_I, ALUOP_BR, ALUOP_PASSB
   } aluop_t;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_AND   = 4'b0010;
   localparam logic [3:0] ALU_OR    = 4'b0011;
   localparam logic [3:0] ALU_XOR   = 4'b0100;
   localparam logic [3:0] ALU_SLT   = 4'b0101;
   localparam logic [3:0] ALU_SLTU  = 4'b0110;
   localparam logic [3:0] ALU_SLL   = 4'b0111;
   localparam logic [3:0] ALU_SRL   = 4'b1000;
   localparam logic [3:0] ALU_SRA   = 4'b1001;
   localparam logic [3:0] ALU_PASSB = 4'b1010;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_A     = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   function automatic logic [2:0] imm_sel(input logic [6:0] op);
      case (opcodetype'(op))
         OP_STORE:         return IMM_S;
         OP_BRANCH:        return IMM_B;
         OP_JAL:           return IMM_J;
         OP_LUI, OP_AUIPC: return IMM_U;
         default:          return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/riscv_mc_ctrl_if.sv
// Controller <-> datapath/bus bundle. Handshake: a memory access is the span
// where MemReq=1; it completes on the first rising edge sampled with MemReady=1.
interface riscv_mc_ctrl_if #(parameter int CNT_W = 32);
   logic [6:0]       op;
   logic [2:0]       funct3;
   logic             funct7b5;
   logic             Zero;
   logic             MemReady;
   logic [2:0]       ImmSrc;
   logic [1:0]       ALUSrcA;
   logic [1:0]       ALUSrcB;
   logic [1:0]       ResultSrc;
   logic             AdrSrc;
   logic [3:0]       ALUControl;
   logic [2:0]       LST;
   logic             LSE;
   logic             IRWrite;
   logic             PCWrite;
   logic             RegWrite;
   logic             MemWrite;
   logic             MemReq;
   logic             Trap;
   logic [1:0]       TrapCause;
   logic [CNT_W-1:0] InstRet;

   modport ctrl (
      input  op, funct3, funct7b5, Zero, MemReady,
      output ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl, LST, LSE,
             IRWrite, PCWrite, RegWrite, MemWrite, MemReq, Trap, TrapCause, InstRet
   );

   modport dp (
      output op, funct3, funct7b5, Zero, MemReady,
      input  ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl, LST, LSE,
             IRWrite, PCWrite, RegWrite, MemWrite, MemReq, Trap, TrapCause, InstRet
   );
endinterface

// File: rtl/riscv_mc_ctrl_aludec.sv
// ALU operation decode from funct3/funct7b5 and operation class, plus the
// branch-taken evaluation from the ALU zero flag.
module riscv_mc_aludec
   import riscv_mc_pkg::*;
#(
   parameter int EXT_BRANCH = 1
) (
   input  aluop_t     aluop_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   input  logic       zero_i,
   output logic [3:0] alu_ctrl_o,
   output logic       taken_o,
   output logic       br_illegal_o
);

   always_comb begin
      alu_ctrl_o   = ALU_ADD;
      taken_o      = 1'b0;
      br_illegal_o = 1'b0;
      case (aluop_i)
         ALUOP_R, ALUOP_I: begin
            case (funct3_i)
               3'b000: alu_ctrl_o = (aluop_i == ALUOP_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
               3'b001: alu_ctrl_o = ALU_SLL;
               3'b010: alu_ctrl_o = ALU_SLT;
               3'b011: alu_ctrl_o = ALU_SLTU;
               3'b100: alu_ctrl_o = ALU_XOR;
               3'b101: alu_ctrl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
               3'b110: alu_ctrl_o = ALU_OR;
               3'b111: alu_ctrl_o = ALU_AND;
            endcase
         end
         ALUOP_BR: begin
            // SLT/SLTU leave Zero=1 when the "less than" test is false.
            case (funct3_i)
               3'b000: begin alu_ctrl_o = ALU_SUB;  taken_o = zero_i;  end
               3'b001: begin alu_ctrl_o = ALU_SUB;  taken_o = !zero_i; end
               3'b100: begin alu_ctrl_o = ALU_SLT;  taken_o = !zero_i; end
               3'b101: begin alu_ctrl_o = ALU_SLT;  taken_o = zero_i;  end
               3'b110: begin alu_ctrl_o = ALU_SLTU; taken_o = !zero_i; end
               3'b111: begin alu_ctrl_o = ALU_SLTU; taken_o = zero_i;  end
               default: br_illegal_o = 1'b1;
            endcase
            if (EXT_BRANCH == 0 && funct3_i != 3'b000) begin
               br_illegal_o = 1'b1;
               taken_o      = 1'b0;
            end
         end
         ALUOP_PASSB: alu_ctrl_o = ALU_PASSB;
         default: ;
      endcase
   end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multicycle RV32I controller: Moore FSM with memory wait states and bus
// timeout, sticky trap state and retired-instruction counter.
module riscv_mc_ctrl
   import riscv_mc_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int EXT_BRANCH  = 1,
   parameter int CNT_W       = 32
) (
   input  logic          clk,
   input  logic          reset,
   riscv_mc_ctrl_if.ctrl bus,
   output statetype      state_o
);

   localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   statetype          state_q, state_d;
   logic [1:0]        cause_q, cause_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  instret_q;

   logic       retire, timeout;
   logic       ir_write, pc_write, reg_write, mem_write, mem_req;
   logic [1:0] src_a, src_b, res_src;
   logic       adr_src, lse;
   aluop_t     aluop;
   logic [3:0] alu_ctrl;
   logic       br_taken, br_illegal;

   riscv_mc_aludec #(.EXT_BRANCH(EXT_BRANCH)) u_aludec (
      .aluop_i      (aluop),
      .funct3_i     (bus.funct3),
      .funct7b5_i   (bus.funct7b5),
      .zero_i       (bus.Zero),
      .alu_ctrl_o   (alu_ctrl),
      .taken_o      (br_taken),
      .br_illegal_o (br_illegal)
   );

   // The last permitted wait cycle still completes if MemReady arrives on it.
   assign timeout = (MEM_TIMEOUT != 0) && !bus.MemReady && (wait_q == WAIT_LAST);

   always_comb begin
      state_d   = state_q;
      cause_d   = cause_q;
      wait_d    = '0;
      retire    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      mem_req   = 1'b0;
      src_a     = SRCA_PC;
      src_b     = SRCB_RD2;
      res_src   = RES_ALUOUT;
      adr_src   = 1'b0;
      lse       = 1'b0;
      aluop     = ALUOP_ADD;
      case (state_q)
         FETCH: begin
            mem_req = 1'b1;
            if (bus.MemReady) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               src_b    = SRCB_FOUR;
               res_src  = RES_ALURES;
               state_d  = DECODE;
            end else if (timeout) begin
               state_d = TRAP;
               cause_d = CAUSE_TIMEOUT;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         DECODE: begin
            src_a = SRCA_OLDPC;
            src_b = SRCB_IMM;
            case (opcodetype'(bus.op))
               OP_LOAD, OP_STORE: state_d = MEMADR;
               OP_R:              state_d = EXECR;
               OP_I:              state_d = EXECI;
               OP_BRANCH:         state_d = BRANCH;
               OP_JAL:            state_d = JAL;
               OP_JALR:           state_d = JALRADR;
               OP_LUI:            state_d = LUI;
               OP_AUIPC:          state_d = AUIPC;
               default: begin
                  state_d = TRAP;
                  cause_d = CAUSE_ILLEGAL;
               end
            endcase
         end
         MEMADR: begin
            src_a   = SRCA_A;
            src_b   = SRCB_IMM;
            state_d = (opcodetype'(bus.op) == OP_LOAD) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (bus.MemReady) begin
               state_d = MEMWB;
            end else if (timeout) begin
               state_d = TRAP;
               cause_d = CAUSE_TIMEOUT;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         MEMWB: begin
            res_src   = RES_DATA;
            reg_write = 1'b1;
            lse       = 1'b1;
            retire    = 1'b1;
            state_d   = FETCH;
         end
         MEMWRITE: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            adr_src   = 1'b1;
            if (bus.MemReady) begin
               retire  = 1'b1;
               state_d = FETCH;
            end else if (timeout) begin
               state_d = TRAP;
               cause_d = CAUSE_TIMEOUT;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         EXECR: begin
            src_a   = SRCA_A;
            aluop   = ALUOP_R;
            state_d = ALUWB;
         end
         EXECI: begin
            src_a   = SRCA_A;
            src_b   = SRCB_IMM;
            aluop   = ALUOP_I;
            state_d = ALUWB;
         end
         ALUWB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            state_d   = FETCH;
         end
         BRANCH: begin
            src_a = SRCA_A;
            aluop = ALUOP_BR;
            if (br_illegal) begin
               state_d = TRAP;
               cause_d = CAUSE_ILLEGAL;
            end else begin
               pc_write = br_taken;
               retire   = 1'b1;
               state_d  = FETCH;
            end
         end
         JAL: begin
            src_a    = SRCA_OLDPC;
            src_b    = SRCB_FOUR;
            pc_write = 1'b1;
            state_d  = ALUWB;
         end
         JALRADR: begin
            src_a   = SRCA_A;
            src_b   = SRCB_IMM;
            state_d = JAL;
         end
         LUI: begin
            src_b   = SRCB_IMM;
            aluop   = ALUOP_PASSB;
            state_d = ALUWB;
         end
         AUIPC: begin
            src_a   = SRCA_OLDPC;
            src_b   = SRCB_IMM;
            state_d = ALUWB;
         end
         TRAP: ;
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= FETCH;
         cause_q   <= CAUSE_NONE;
         wait_q    <= '0;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         wait_q  <= wait_d;
         if (retire) instret_q <= instret_q + 1'b1;
      end
   end

   // Strobes are gated by reset so an in-flight request drops immediately.
   assign bus.IRWrite    = ir_write  & reset;
   assign bus.PCWrite    = pc_write  & reset;
   assign bus.RegWrite   = reg_write & reset;
   assign bus.MemWrite   = mem_write & reset;
   assign bus.MemReq     = mem_req   & reset;
   assign bus.ImmSrc     = imm_sel(bus.op);
   assign bus.ALUSrcA    = src_a;
   assign bus.ALUSrcB    = src_b;
   assign bus.ResultSrc  = res_src;
   assign bus.AdrSrc     = adr_src;
   assign bus.ALUControl = alu_ctrl;
   assign bus.LST        = bus.funct3;
   assign bus.LSE        = lse;
   assign bus.Trap       = (state_q == TRAP);
   assign bus.TrapCause  = cause_q;
   assign bus.InstRet    = instret_q;
   assign state_o        = state_q;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Directed bench for riscv_mc_ctrl: per-cycle expected control words are
// queued by the driver and compared by a negedge monitor.
module tb_riscv_mc_ctrl;
  import riscv_mc_pkg::*;

  typedef struct packed {
    statetype    st;
    logic [2:0]  imm;
    logic [1:0]  srca;
    logic [1:0]  srcb;
    logic [1:0]  res;
    logic        adr;
    logic [3:0]  alu;
    logic [2:0]  lst;
    logic        lse;
    logic        irw;
    logic        pcw;
    logic        rgw;
    logic        mw;
    logic        mr;
    logic        trap;
    logic [1:0]  cause;
    logic [31:0] ir;
  } obs_t;
  localparam int OW = $bits(obs_t);

  // clock / reset
  logic clk = 1'b0;
  logic rst0 = 1'b0;
  logic rst1 = 1'b0;
  always #5 clk = ~clk;

  riscv_mc_ctrl_if b0 ();
  riscv_mc_ctrl_if b1 ();
  statetype st0, st1;

  riscv_mc_ctrl dut (.clk(clk), .reset(rst0), .bus(b0), .state_o(st0));
  riscv_mc_ctrl #(.EXT_BRANCH(0)) dut_nb (.clk(clk), .reset(rst1), .bus(b1), .state_o(st1));

  obs_t obs0, obs1;
  assign obs0 = {st0, b0.ImmSrc, b0.ALUSrcA, b0.ALUSrcB, b0.ResultSrc, b0.AdrSrc, b0.ALUControl,
                 b0.LST, b0.LSE, b0.IRWrite, b0.PCWrite, b0.RegWrite, b0.MemWrite, b0.MemReq,
                 b0.Trap, b0.TrapCause, b0.InstRet};
  assign obs1 = {st1, b1.ImmSrc, b1.ALUSrcA, b1.ALUSrcB, b1.ResultSrc, b1.AdrSrc, b1.ALUControl,
                 b1.LST, b1.LSE, b1.IRWrite, b1.PCWrite, b1.RegWrite, b1.MemWrite, b1.MemReq,
                 b1.Trap, b1.TrapCause, b1.InstRet};

  // scoreboard
  logic [OW-1:0] exp_q[2][$];
  logic [OW-1:0] msk_q[2][$];
  string         nam_q[2][$];
  int tests = 0;
  int failed = 0;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (exp_q[k].size() != 0) begin
        logic [OW-1:0] ev, mv, gv;
        string nm;
        ev = exp_q[k].pop_front();
        mv = msk_q[k].pop_front();
        nm = nam_q[k].pop_front();
        gv = (k == 0) ? obs0 : obs1;
        tests++;
        if ((gv & mv) !== (ev & mv)) begin
          failed++;
          $display("FAIL %s: got %h, expected %h (mask %h)", nm, gv, ev, mv);
        end
      end
    end
  end

  // driver
  int          cur = 0;
  obs_t        e;
  logic [31:0] ret = 0;
  logic [6:0]  d_op = 0;
  logic [2:0]  d_f3 = 0;
  logic        d_f7 = 0, d_z = 0, d_rdy = 0, d_rst = 0;

  function automatic obs_t blank(statetype st, logic [2:0] imm, logic [31:0] ir);
    obs_t r;
    r = '0;
    r.st = st;
    r.imm = imm;
    r.ir = ir;
    return r;
  endfunction

  task automatic set_ins(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    d_op = op; d_f3 = f3; d_f7 = f7;
  endtask

  task automatic step(input string nm, input logic [OW-1:0] m = {OW{1'b1}});
    @(posedge clk);
    #1;
    if (cur == 0) begin
      b0.op = d_op; b0.funct3 = d_f3; b0.funct7b5 = d_f7; b0.Zero = d_z; b0.MemReady = d_rdy;
      rst0 = d_rst;
    end else begin
      b1.op = d_op; b1.funct3 = d_f3; b1.funct7b5 = d_f7; b1.Zero = d_z; b1.MemReady = d_rdy;
      rst1 = d_rst;
    end
    e.lst = d_f3;
    exp_q[cur].push_back(e);
    msk_q[cur].push_back(m);
    nam_q[cur].push_back(nm);
  endtask

  task automatic fetch_ok(input string nm, input logic [2:0] imm);
    d_rdy = 1'b1;
    e = blank(FETCH, imm, ret);
    e.mr = 1; e.irw = 1; e.pcw = 1; e.srcb = 2'b10; e.res = 2'b10;
    step(nm);
  endtask

  task automatic decode(input string nm, input logic [2:0] imm);
    d_rdy = 1'b0;
    e = blank(DECODE, imm, ret);
    e.srca = 2'b01; e.srcb = 2'b01;
    step(nm);
  endtask

  task automatic aluwb(input string nm, input logic [2:0] imm);
    e = blank(ALUWB, imm, ret);
    e.rgw = 1;
    step(nm);
    ret++;
  endtask

  task automatic branch(input string nm, input logic [2:0] f3, input logic z,
                        input logic [3:0] alu, input logic pcw);
    set_ins(7'h63, f3, 1'b0);
    d_z = z;
    fetch_ok({nm, "_fetch"}, 3'b010);
    decode({nm, "_decode"}, 3'b010);
    e = blank(BRANCH, 3'b010, ret);
    e.srca = 2'b10; e.alu = alu; e.pcw = pcw;
    step(nm);
    ret++;
    d_z = 1'b0;
  endtask

  obs_t mm;

  initial begin
    b0.op = 0; b0.funct3 = 0; b0.funct7b5 = 0; b0.Zero = 0; b0.MemReady = 0;
    b1.op = 0; b1.funct3 = 0; b1.funct7b5 = 0; b1.Zero = 0; b1.MemReady = 0;
    repeat (2) @(posedge clk);

    // reset state: strobes low, FETCH, counters cleared
    set_ins(7'h33, 3'b000, 1'b0);
    d_rst = 0;
    e = blank(FETCH, 3'b000, 0);
    step("reset_state");
    d_rst = 1;

    // add x3,x1,x2
    fetch_ok("add_fetch", 3'b000);
    decode("add_decode", 3'b000);
    e = blank(EXECR, 3'b000, ret); e.srca = 2'b10; e.alu = 4'b0000;
    step("add_execr");
    aluwb("add_aluwb", 3'b000);

    // sub x3,x1,x2
    set_ins(7'h33, 3'b000, 1'b1);
    fetch_ok("sub_fetch", 3'b000);
    decode("sub_decode", 3'b000);
    e = blank(EXECR, 3'b000, ret); e.srca = 2'b10; e.alu = 4'b0001;
    step("sub_execr");
    aluwb("sub_aluwb", 3'b000);

    // addi with imm bit 30 set stays ADD
    set_ins(7'h13, 3'b000, 1'b1);
    fetch_ok("addi_fetch", 3'b000);
    decode("addi_decode", 3'b000);
    e = blank(EXECI, 3'b000, ret); e.srca = 2'b10; e.srcb = 2'b01; e.alu = 4'b0000;
    step("addi_execi");
    aluwb("addi_aluwb", 3'b000);

    // lw with 5 wait cycles
    set_ins(7'h03, 3'b010, 1'b0);
    fetch_ok("lw_fetch", 3'b000);
    decode("lw_decode", 3'b000);
    e = blank(MEMADR, 3'b000, ret); e.srca = 2'b10; e.srcb = 2'b01;
    step("lw_memadr");
    for (int i = 0; i < 6; i++) begin
      d_rdy = (i == 5);
      e = blank(MEMREAD, 3'b000, ret); e.mr = 1; e.adr = 1;
      step("lw_memread");
    end
    d_rdy = 0;
    e = blank(MEMWB, 3'b000, ret); e.res = 2'b01; e.rgw = 1; e.lse = 1;
    step("lw_memwb");
    ret++;

    branch("bge_z1",  3'b101, 1'b1, 4'b0101, 1'b1);
    branch("bltu_z1", 3'b110, 1'b1, 4'b0110, 1'b0);
    branch("beq_z0",  3'b000, 1'b0, 4'b0001, 1'b0);

    // jalr x1,8(x2)
    set_ins(7'h67, 3'b000, 1'b0);
    fetch_ok("jalr_fetch", 3'b000);
    decode("jalr_decode", 3'b000);
    e = blank(JALRADR, 3'b000, ret); e.srca = 2'b10; e.srcb = 2'b01;
    step("jalr_adr");
    e = blank(JAL, 3'b000, ret); e.srca = 2'b01; e.srcb = 2'b10; e.pcw = 1;
    step("jalr_jal");
    aluwb("jalr_aluwb", 3'b000);

    // lui
    set_ins(7'h37, 3'b000, 1'b0);
    fetch_ok("lui_fetch", 3'b100);
    decode("lui_decode", 3'b100);
    e = blank(LUI, 3'b100, ret); e.srcb = 2'b01; e.alu = 4'b1010;
    step("lui_exec");
    aluwb("lui_aluwb", 3'b100);

    // sw that never completes: 16 request cycles then timeout trap
    set_ins(7'h23, 3'b010, 1'b0);
    fetch_ok("sw_fetch", 3'b001);
    decode("sw_decode", 3'b001);
    e = blank(MEMADR, 3'b001, ret); e.srca = 2'b10; e.srcb = 2'b01;
    step("sw_memadr");
    for (int i = 0; i < 16; i++) begin
      e = blank(MEMWRITE, 3'b001, ret); e.mr = 1; e.mw = 1; e.adr = 1;
      step("sw_memwrite_wait");
    end
    for (int i = 0; i < 3; i++) begin
      d_rdy = (i == 1);
      e = blank(TRAP, 3'b001, ret); e.trap = 1; e.cause = 2'b10;
      step("sw_trap_timeout");
    end
    d_rdy = 0;

    d_rst = 0;
    ret = 0;
    e = blank(FETCH, 3'b001, 0);
    step("reset_after_timeout");
    d_rst = 1;
    e = blank(FETCH, 3'b001, 0); e.mr = 1;
    step("fetch_wait_after_reset");

    // lw completing on the last allowed wait cycle: no trap
    set_ins(7'h03, 3'b000, 1'b0);
    fetch_ok("lw16_fetch", 3'b000);
    decode("lw16_decode", 3'b000);
    e = blank(MEMADR, 3'b000, ret); e.srca = 2'b10; e.srcb = 2'b01;
    step("lw16_memadr");
    for (int i = 0; i < 16; i++) begin
      d_rdy = (i == 15);
      e = blank(MEMREAD, 3'b000, ret); e.mr = 1; e.adr = 1;
      step("lw16_memread");
    end
    d_rdy = 0;
    e = blank(MEMWB, 3'b000, ret); e.res = 2'b01; e.rgw = 1; e.lse = 1;
    step("lw16_memwb");
    ret++;

    // illegal opcode, then reset mid-trap
    set_ins(7'h7F, 3'b000, 1'b0);
    fetch_ok("ill_fetch", 3'b000);
    decode("ill_decode", 3'b000);
    for (int i = 0; i < 2; i++) begin
      e = blank(TRAP, 3'b000, ret); e.trap = 1; e.cause = 2'b01;
      step("ill_trap");
    end
    d_rst = 0;
    ret = 0;
    e = blank(FETCH, 3'b000, 0);
    step("reset_mid_trap");
    d_rst = 1;
    e = blank(FETCH, 3'b000, 0); e.mr = 1;
    step("memreq_after_reset");

    // EXT_BRANCH=0 instance: bne is illegal
    cur = 1;
    ret = 0;
    set_ins(7'h63, 3'b001, 1'b0);
    d_z = 0;
    fetch_ok("nb_bne_fetch", 3'b010);
    decode("nb_bne_decode", 3'b010);
    e = blank(BRANCH, 3'b010, 0); e.srca = 2'b10;
    mm = '1; mm.alu = '0;
    step("nb_bne_branch", mm);
    e = blank(TRAP, 3'b010, 0); e.trap = 1; e.cause = 2'b01;
    step("nb_bne_trap");

    @(negedge clk);
    #1;
    tests++;
    if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
      failed++;
      $display("FAIL queue_drain: got %0d/%0d left, expected 0/0", exp_q[0].size(), exp_q[1].size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
